uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit-side serializer of the UART. It sits directly downstream of the transmit load controller. It captures a byte when that controller asserts `load`, then shifts out one frame on `tx`: start bit, 8 data bits LSB first, optional parity bit, and 1 or 2 stop bits. Each bit is timed by the 16x oversampling baud tick. Its `done` output is the readiness signal the load controller waits on before issuing the next `load`.

## Interface
Parameters:
- `DATA_BITS`, 8: payload width.
- `OVERSAMPLE`, 16: baud ticks per bit.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-low reset.
- `baud_tick`  in  1  one-`clk`-wide pulse at 16x baud rate, synchronous to `clk`.
- `load`  in  1  load request from the load controller; may stay high for many `clk` cycles.
- `tx_data`  in  DATA_BITS  byte to send; sampled on acceptance.
- `parity_en`  in  1  1 = append parity bit; sampled on acceptance.
- `parity_odd`  in  1  1 = odd parity, 0 = even; sampled on acceptance.
- `two_stop`  in  1  1 = two stop bits; sampled on acceptance.
- `tx`  out  1  serial line; idles high.
- `done`  out  1  high while idle and ready to accept a byte.
- `busy`  out  1  inverse of `done`.
- `frame_done`  out  1  one-`clk` pulse when the last stop bit completes.

## Operation
- State machine with states IDLE, START, DATA, PARITY and STOP.
- Acceptance happens only in IDLE, on a rising edge of `load` (`load`=1 and the registered `load_q`=0). On acceptance:
  - capture `tx_data` and the three config bits into a shift register and config registers;
  - clear `tick_cnt` and `bit_cnt`;
  - go to START.
- `tx` value per state:
  - IDLE: 1.
  - START: 0.
  - DATA: `shreg[0]`.
  - PARITY: XOR of the captured data, inverted when `parity_odd`=1.
  - STOP: 1.
- `tick_cnt` (4 bit) increments on each `baud_tick` outside IDLE. When it is 15 and `baud_tick` is high, the bit ends: `tick_cnt` wraps to 0 and the state advances.
- Transitions at bit end:
  - START -> DATA.
  - DATA: shift `shreg` right and increment `bit_cnt`. After the bit with `bit_cnt`=DATA_BITS-1, go to PARITY if `parity_en`=1, otherwise STOP.
  - PARITY -> STOP.
  - STOP: go to IDLE after the 1st stop bit (`two_stop`=0) or the 2nd (`two_stop`=1). Pulse `frame_done` in that same cycle.
- A `load` rising edge outside IDLE is discarded. It is not queued.
- A `load` held high across the return to IDLE does not retrigger; a fresh rising edge is required.
- Changes to `tx_data` or config after acceptance have no effect on the current frame.
- `baud_tick` in IDLE is ignored and `tick_cnt` stays at 0.

## Timing
- Reset values (`reset`=0 at a `clk` edge): state IDLE, `tx`=1, `done`=1, `busy`=0, `frame_done`=0, counters 0, `load_q`=0.
- Reset mid-frame: `tx` returns high at the next edge and the frame is abandoned. No `frame_done` pulse.
- Acceptance latency: `tx` falls and `done` falls on the `clk` edge that samples the `load` rising edge.
- Each bit lasts exactly 16 `baud_tick` pulses. The start bit additionally includes the sub-tick interval between acceptance and the first tick.
- Frame length in ticks = 16 x (1 + DATA_BITS + `parity_en` + 1 + `two_stop`). With 8 data bits this is 160 to 192.
- `done` rises on the same edge that `frame_done` pulses and `tx` is already 1.
- The earliest next acceptance is one `clk` after `done` rises.
- All outputs are registered.

## Structure
- Package `uart_tx_pkg` holds:
  - the state enum `tx_state_e`;
  - `OVERSAMPLE`;
  - the default `DATA_BITS`;
  - the parity-mode constants.
- One natural sub-module, `uart_tx_bit_timer`: the 4-bit tick counter. It has inputs `clk`, `reset`, `baud_tick`, `run` and output `bit_end`. The FSM and shift register stay in the top.

## Test plan
- Reset: hold `reset`=0 for 4 cycles -> `tx`=1, `done`=1, `busy`=0, `frame_done`=0. Assert reset during a DATA bit -> `tx`=1 and `done`=1 after one edge.
- 8N1 frame: 0x55 with `parity_en`=0, `two_stop`=0 -> `tx` = 0,1,0,1,0,1,0,1,0,1, each exactly 16 ticks. `frame_done` pulses once after 160 ticks.
- Parity: 0x55 (four ones) -> parity bit 0 when even, 1 when odd. 0x07 even -> parity bit 1. Frame is 176 ticks.
- Two stop bits: 0xA5 with `two_stop`=1 and no parity -> stop high for 32 ticks. `frame_done` at tick 176.
- Load handling:
  - `load` held high for 40 cycles -> exactly one frame;
  - a second `load` edge mid-frame -> ignored, `tx` sequence unchanged;
  - changing `tx_data` after acceptance -> no effect on the frame.
- Back-to-back: pulse `load` one cycle after `done` rises -> new start bit follows immediately. No extra idle bit beyond the stop bits.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
package uart_tx_pkg;

  localparam int OVERSAMPLE        = 16;
  localparam int DEFAULT_DATA_BITS = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Oversampling tick counter: flags the baud tick that completes the current bit.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
#(
  parameter int TICKS = OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_tick,
  input  logic run,
  output logic bit_end
);

  localparam int CNT_W = $clog2(TICKS);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] tick_cnt_r;

  // Held at zero while idle so every frame starts its start bit from a clean count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_r <= '0;
    end else if (!run) begin
      tick_cnt_r <= '0;
    end else if (baud_tick) begin
      if (tick_cnt_r == LAST_TICK) begin
        tick_cnt_r <= '0;
      end else begin
        tick_cnt_r <= tick_cnt_r + 1'b1;
      end
    end else begin
      tick_cnt_r <= tick_cnt_r;
    end
  end

  assign bit_end = run && baud_tick && (tick_cnt_r == LAST_TICK);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  output logic                 tx,
  output logic                 done,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ (odd == PARITY_ODD);
  endfunction

  tx_state_e              state_r, state_n;
  logic [DATA_BITS-1:0]   shreg_r, shreg_n;
  logic [BIT_CNT_W-1:0]   bit_cnt_r, bit_cnt_n;
  logic                   par_en_r, par_en_n;
  logic                   par_bit_r, par_bit_n;
  logic                   two_stop_r, two_stop_n;
  logic                   stop_cnt_r, stop_cnt_n;
  logic                   load_q_r;
  logic                   tx_r, tx_n;
  logic                   done_r, done_n;
  logic                   busy_r, busy_n;
  logic                   frame_done_r, frame_done_n;
  logic                   accept_s;
  logic                   bit_end_s;
  logic                   run_s;

  assign run_s    = (state_r != ST_IDLE);
  assign accept_s = (state_r == ST_IDLE) && load && !load_q_r;

  uart_tx_bit_timer #(
    .TICKS(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .baud_tick(baud_tick),
    .run      (run_s),
    .bit_end  (bit_end_s)
  );

  // Next state and next registered outputs; tx is derived from the next state so it is glitch-free.
  always_comb begin
    state_n      = state_r;
    shreg_n      = shreg_r;
    bit_cnt_n    = bit_cnt_r;
    par_en_n     = par_en_r;
    par_bit_n    = par_bit_r;
    two_stop_n   = two_stop_r;
    stop_cnt_n   = stop_cnt_r;
    frame_done_n = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          shreg_n    = tx_data;
          par_en_n   = parity_en;
          par_bit_n  = parity_of(tx_data, parity_odd);
          two_stop_n = two_stop;
          bit_cnt_n  = '0;
          stop_cnt_n = 1'b0;
          state_n    = ST_START;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_n = ST_DATA;
        end else begin
          state_n = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shreg_n   = {1'b0, shreg_r[DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt_r + 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            state_n = par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            state_n = ST_DATA;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_n = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          if (two_stop_r && !stop_cnt_r) begin
            stop_cnt_n = 1'b1;
            state_n    = ST_STOP;
          end else begin
            state_n      = ST_IDLE;
            frame_done_n = 1'b1;
          end
        end else begin
          state_n = ST_STOP;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    case (state_n)
      ST_IDLE:   tx_n = 1'b1;
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shreg_n[0];
      ST_PARITY: tx_n = par_bit_n;
      ST_STOP:   tx_n = 1'b1;
      default:   tx_n = 1'b1;
    endcase

    done_n = (state_n == ST_IDLE);
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      shreg_r      <= '0;
      bit_cnt_r    <= '0;
      par_en_r     <= 1'b0;
      par_bit_r    <= 1'b0;
      two_stop_r   <= 1'b0;
      stop_cnt_r   <= 1'b0;
      load_q_r     <= 1'b0;
      tx_r         <= 1'b1;
      done_r       <= 1'b1;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      shreg_r      <= shreg_n;
      bit_cnt_r    <= bit_cnt_n;
      par_en_r     <= par_en_n;
      par_bit_r    <= par_bit_n;
      two_stop_r   <= two_stop_n;
      stop_cnt_r   <= stop_cnt_n;
      load_q_r     <= load;
      tx_r         <= tx_n;
      done_r       <= done_n;
      busy_r       <= busy_n;
      frame_done_r <= frame_done_n;
    end
  end

  assign tx         = tx_r;
  assign done       = done_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer using an expected-bit scoreboard queue.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_tick;
  logic       load;
  logic [7:0] tx_data;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       tx;
  logic       done;
  logic       busy;
  logic       frame_done;

  int   total = 0;
  int   bad   = 0;
  int   div   = 0;
  logic exp_q[$];

  uart_tx_serializer #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .load      (load),
    .tx_data   (tx_data),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .two_stop  (two_stop),
    .tx        (tx),
    .done      (done),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // One-clk baud tick every 4 clocks, changing 2 ns after the rising edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      baud_tick = (div == 3);
      div = (div + 1) % 4;
    end
  end

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic po, input logic ts);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pe) exp_q.push_back((^d) ^ po);
    exp_q.push_back(1'b1);
    if (ts) exp_q.push_back(1'b1);
  endtask

  task automatic drive_load(input string name, input logic [7:0] d, input logic pe,
                            input logic po, input logic ts);
    @(negedge clk);
    tx_data    = d;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    load       = 1'b1;
    push_frame(d, pe, po, ts);
    @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL %s_accept: tx=%b done=%b busy=%b expected tx=0 done=0 busy=1",
               name, tx, done, busy);
    end
  endtask

  task automatic wait_tick(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (baud_tick) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  // Pops the scoreboard: every bit must hold for 16 ticks, then frame_done/done on the last tick edge.
  task automatic check_frame(input string name);
    bit   to;
    logic exp_bit;
    int   bit_idx;
    to = 1'b0;
    bit_idx = 0;
    while (exp_q.size() > 0 && !to) begin
      exp_bit = exp_q.pop_front();
      for (int t = 0; t < 16; t++) begin
        wait_tick(to);
        if (to) break;
        total++;
        if (tx !== exp_bit || frame_done !== 1'b0 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s_bit%0d_tick%0d: tx=%b frame_done=%b done=%b expected tx=%b frame_done=0 done=0",
                   name, bit_idx, t, tx, frame_done, done, exp_bit);
        end
      end
      bit_idx++;
    end
    if (to) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no baud tick seen, expected one within 12 cycles", name);
      exp_q.delete();
    end else begin
      @(posedge clk);
      #1;
      total++;
      if (frame_done !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
        bad++;
        $display("FAIL %s_end: frame_done=%b done=%b busy=%b tx=%b expected 1 1 0 1",
                 name, frame_done, done, busy, tx);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load = 1'b0; tx_data = 8'h00;
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL reset_done: got %b expected 1", done); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (tx !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL idle_ticks_ignored: tx=%b done=%b expected 1 1", tx, done);
    end
  endtask

  task automatic test_8n1();
    drive_load("f8n1", 8'h55, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    check_frame("f8n1");
    @(posedge clk);
    #1;
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL f8n1_single_pulse: frame_done=%b expected 0", frame_done);
    end
  endtask

  task automatic test_parity();
    logic [7:0] d_tab[3]  = '{8'h55, 8'h55, 8'h07};
    logic       po_tab[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_load($sformatf("par%0d", i), d_tab[i], 1'b1, po_tab[i], 1'b0);
      load = 1'b0;
      check_frame($sformatf("par%0d", i));
    end
  endtask

  task automatic test_two_stop();
    drive_load("stop2", 8'hA5, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    check_frame("stop2");
    drive_load("stop2par", 8'h3C, 1'b1, 1'b1, 1'b1);
    load = 1'b0;
    check_frame("stop2par");
  endtask

  task automatic test_load_hold();
    drive_load("hold40", 8'h96, 1'b0, 1'b0, 1'b0);
    fork
      check_frame("hold40");
      begin
        repeat (40) @(posedge clk);
        #1;
        load = 1'b0;
      end
    join
    drive_load("holdlong", 8'h3C, 1'b1, 1'b0, 1'b0);
    check_frame("holdlong");
    repeat (20) @(negedge clk);
    total++;
    if (done !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL holdlong_no_retrigger: done=%b tx=%b busy=%b expected 1 1 0", done, tx, busy);
    end
    load = 1'b0;
  endtask

  task automatic test_mid_frame_load();
    drive_load("midload", 8'hC3, 1'b1, 1'b0, 1'b0);
    load = 1'b0;
    fork
      check_frame("midload");
      begin
        repeat (200) @(negedge clk);
        load       = 1'b1;
        tx_data    = 8'h00;
        parity_en  = 1'b0;
        parity_odd = 1'b1;
        two_stop   = 1'b1;
        @(negedge clk);
        load = 1'b0;
      end
    join
  endtask

  task automatic test_back_to_back();
    drive_load("b2b_a", 8'h0F, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    check_frame("b2b_a");
    drive_load("b2b_b", 8'hF0, 1'b1, 1'b1, 1'b0);
    load = 1'b0;
    check_frame("b2b_b");
  endtask

  task automatic test_reset_mid();
    bit saw_pulse;
    bit saw_low;
    drive_load("rstmid", 8'hAA, 1'b0, 1'b0, 1'b0);
    load = 1'b0;
    repeat (120) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_state: tx=%b done=%b busy=%b frame_done=%b expected 1 1 0 0",
               tx, done, busy, frame_done);
    end
    @(negedge clk);
    reset = 1'b1;
    saw_pulse = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (frame_done) saw_pulse = 1'b1;
      if (!tx) saw_low = 1'b1;
    end
    total++;
    if (saw_pulse || saw_low) begin
      bad++;
      $display("FAIL rstmid_abandoned: frame_done_seen=%b tx_low_seen=%b expected 0 0", saw_pulse, saw_low);
    end
    drive_load("after_rst", 8'h81, 1'b1, 1'b0, 1'b1);
    load = 1'b0;
    check_frame("after_rst");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_load_hold();
    test_mid_frame_load();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
